// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter: one input bit per clock, BIT_SZ cycles busy, done pulse after.
// start is ignored while busy (no queueing); optional leading-zero mask `blank` when BCD_BLANK_EN is defined.
module bin_to_bcd_seq #(
  parameter int BIT_SZ = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [BIT_SZ-1:0] bin,
  output logic              busy,
  output logic              done,
`ifdef BCD_BLANK_EN
  output logic [3:0]        blank,
`endif
  output logic [15:0]       bcd
);

  localparam int W = 16 + BIT_SZ;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]   state;
  logic [W-1:0] work;
  logic [W-1:0] work_adj;
  logic [W-1:0] work_nxt;
  logic [3:0]   cnt;
  logic         last;

  // Correction is applied to the pre-shift digit fields sitting above the binary part.
  always_comb begin
    work_adj = work;
    for (int i = 0; i < 4; i++) begin
      if (work[BIT_SZ + 4*i +: 4] >= 4'd5) begin
        work_adj[BIT_SZ + 4*i +: 4] = work[BIT_SZ + 4*i +: 4] + 4'd3;
      end
    end
    work_nxt = work_adj << 1;
  end

  assign last = (cnt == 4'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= 16'h0000;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          work  <= {16'b0, bin};
          cnt   <= 4'(BIT_SZ);
          busy  <= 1'b1;
          state <= SHIFT;
        end
      end else begin
        work <= work_nxt;
        cnt  <= cnt - 4'd1;
        if (last) begin
          bcd   <= work_nxt[W-1 -: 16];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end

`ifdef BCD_BLANK_EN
  // A digit is blanked only if it and all more-significant digits are zero; units always shown.
  function automatic logic [3:0] lead_zero_mask(input logic [15:0] d);
    logic [3:0] m;
    m[3] = (d[15:12] == 4'd0);
    m[2] = m[3] && (d[11:8] == 4'd0);
    m[1] = m[2] && (d[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blank <= 4'b1110;
    end else if (state == SHIFT && last) begin
      blank <= lead_zero_mask(work_nxt[W-1 -: 16]);
    end
  end
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized and directed bench for bin_to_bcd_seq against a decimal-arithmetic reference.
module tb_bin_to_bcd_seq;
  localparam int BIT_SZ = 10;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b0;
  logic              start   = 1'b0;
  logic [BIT_SZ-1:0] bin     = '0;
  logic              busy;
  logic              done;
  logic [15:0]       bcd;
`ifdef BCD_BLANK_EN
  logic [3:0]        blank;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  bin_to_bcd_seq #(.BIT_SZ(BIT_SZ)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
`ifdef BCD_BLANK_EN
    .blank   (blank),
`endif
    .bcd     (bcd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic [15:0] ref_bcd(input int n);
    int v;
    v = (n / 1000 % 10) * 4096 + (n / 100 % 10) * 256 + (n / 10 % 10) * 16 + (n % 10);
    return 16'(v);
  endfunction

  function automatic logic [3:0] ref_blank(input int n);
    return {n < 1000, n < 100, n < 10, 1'b0};
  endfunction

  task automatic wait_done(output int cycles, output bit ok);
    ok = 0;
    cycles = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (done) begin
        ok = 1;
        cycles = c;
        return;
      end
    end
  endtask

  // poke > 0: pulse start with bin=7 in that busy cycle, then expect nothing further.
  task automatic convert(input int v, input int poke);
    int nb;
    int extra;
    bit seen;
    bit stable_ok;
    logic [15:0] held;
    held = bcd;
    @(negedge clock);
    bin = BIT_SZ'(v);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    bin = BIT_SZ'($urandom_range(0, 1023));
    nb = 0;
    seen = 0;
    stable_ok = 1;
    for (int c = 0; c < 40; c++) begin
      start = 1'b0;
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nb++;
      if (bcd !== held) stable_ok = 0;
      if (poke != 0 && nb == poke) begin
        start = 1'b1;
        bin = BIT_SZ'(7);
      end
      @(negedge clock);
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("busy_cycles", 32'(nb), 32'(BIT_SZ));
    check("bcd_hold", 32'(stable_ok), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
    check("bcd", 32'(bcd), 32'(ref_bcd(v)));
`ifdef BCD_BLANK_EN
    check("blank", 32'(blank), 32'(ref_blank(v)));
`endif
    @(negedge clock);
    check("done_one_cycle", 32'(done), 32'd0);
    if (poke != 0) begin
      extra = 0;
      for (int c = 0; c < 15; c++) begin
        if (done || busy) extra++;
        @(negedge clock);
      end
      check("no_requeue", 32'(extra), 32'd0);
      check("bcd_after_ignore", 32'(bcd), 32'(ref_bcd(v)));
    end
  endtask

  initial begin
    int cyc;
    int dcount;
    bit ok;

    @(negedge clock);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
`ifdef BCD_BLANK_EN
    check("rst_blank", 32'(blank), 32'b1110);
`endif
    reset_n = 1'b1;
    @(negedge clock);

    convert(1023, 0);
    convert(0, 0);
    convert(59, 0);
    convert(999, 0);
    convert(512, 4);

    // Abort a conversion of 800 with reset in its fifth busy cycle.
    @(negedge clock);
    bin = BIT_SZ'(800);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'h0);
`ifdef BCD_BLANK_EN
    check("mid_rst_blank", 32'(blank), 32'b1110);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      if (done) dcount++;
    end
    check("mid_rst_no_done", 32'(dcount), 32'd0);
    check("mid_rst_bcd_kept", 32'(bcd), 32'h0);
    convert(800, 0);

    // start held high: back-to-back conversions 100 then 200.
    @(negedge clock);
    bin = BIT_SZ'(100);
    start = 1'b1;
    @(negedge clock);
    bin = BIT_SZ'(200);
    wait_done(cyc, ok);
    check("b2b_first_done", 32'(ok), 32'd1);
    check("b2b_first_lat", 32'(cyc), 32'(BIT_SZ));
    check("b2b_first_bcd", 32'(bcd), 32'h0100);
    wait_done(cyc, ok);
    start = 1'b0;
    check("b2b_second_done", 32'(ok), 32'd1);
    check("b2b_period", 32'(cyc), 32'(BIT_SZ + 1));
    check("b2b_second_bcd", 32'(bcd), 32'h0200);
    dcount = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      if (done) dcount++;
    end
    check("b2b_stops", 32'(dcount), 32'd0);

    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      convert(int'($urandom_range(0, 1023)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
